// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: PS/2 set-2 scan-code constants, decoder state/key enums and key-map helpers.
// Build option: PS2_ARROW_ALIAS_EN maps extended arrow codes onto the keypad 2/4/6/8 flags.
`default_nettype none

package ps2_kbd_pkg;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam logic [7:0] PS2_KEY_2     = 8'h72;
  localparam logic [7:0] PS2_KEY_4     = 8'h6B;
  localparam logic [7:0] PS2_KEY_6     = 8'h74;
  localparam logic [7:0] PS2_KEY_8     = 8'h75;
  localparam logic [7:0] PS2_KEY_ENTER = 8'h5A;
  localparam logic [7:0] PS2_BAT       = 8'hAA;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_OVR_LO    = 8'h00;
  localparam logic [7:0] PS2_OVR_HI    = 8'hFF;

  localparam int NUM_KEYS = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } ps2_state_t;

  // Bit positions within the flag vector and key_make_pulse: {ENTER,8,6,4,2}.
  typedef enum logic [2:0] {
    K2     = 3'd0,
    K4     = 3'd1,
    K6     = 3'd2,
    K8     = 3'd3,
    KENTER = 3'd4
  } key_idx_t;

  function automatic logic [NUM_KEYS-1:0] plain_key_mask(input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code)
      PS2_KEY_2:     m[K2]     = 1'b1;
      PS2_KEY_4:     m[K4]     = 1'b1;
      PS2_KEY_6:     m[K6]     = 1'b1;
      PS2_KEY_8:     m[K8]     = 1'b1;
      PS2_KEY_ENTER: m[KENTER] = 1'b1;
      default:       m         = '0;
    endcase
    return m;
  endfunction

  function automatic logic [NUM_KEYS-1:0] ext_key_mask(input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code)
      PS2_KEY_ENTER: m[KENTER] = 1'b1;
`ifdef PS2_ARROW_ALIAS_EN
      PS2_KEY_2:     m[K2]     = 1'b1;
      PS2_KEY_4:     m[K4]     = 1'b1;
      PS2_KEY_6:     m[K6]     = 1'b1;
      PS2_KEY_8:     m[K8]     = 1'b1;
`endif
      default:       m         = '0;
    endcase
    return m;
  endfunction

  function automatic logic is_discard(input logic [7:0] code);
    return (code == PS2_BAT) || (code == PS2_ACK) ||
           (code == PS2_ECHO) || (code == PS2_RESEND);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_seq_timer.sv
// ps2_seq_timer: saturating inter-byte timeout counter; expired pulses in the cycle the count hits TIMEOUT_CYCLES-1.
`default_nettype none

module ps2_seq_timer #(
  parameter int TIMEOUT_CYCLES = 1_600_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  // A byte arriving in the expiry cycle takes precedence, so clear masks the pulse.
  assign expired = run && !clear && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/ps2_keypad_decoder.sv
// ps2_keypad_decoder: PS/2 set-2 byte stream to keypad 2/4/6/8/ENTER level flags and make pulses.
// Build option: PS2_ARROW_ALIAS_EN (extended arrow keys alias the keypad direction flags).
`default_nettype none

module ps2_keypad_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_600_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_new,
  input  logic       din_err,
  output logic       Key_2_is_pressed,
  output logic       Key_4_is_pressed,
  output logic       Key_6_is_pressed,
  output logic       Key_8_is_pressed,
  output logic       Key_ENTER_is_pressed,
  output logic [4:0] key_make_pulse,
  output logic       seq_error
);

  ps2_state_t          state;
  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] plain_mask;
  logic [NUM_KEYS-1:0] ext_mask;
  logic                expired;

  assign plain_mask = plain_key_mask(din);
  assign ext_mask   = ext_key_mask(din);

  ps2_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (din_new),
    .run    (state != S_IDLE),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      keys           <= '0;
      key_make_pulse <= '0;
      seq_error      <= 1'b0;
    end else begin
      key_make_pulse <= '0;
      seq_error      <= 1'b0;
      if (din_err) begin
        state     <= S_IDLE;
        seq_error <= 1'b1;
      end else if (din_new) begin
        if (din == PS2_OVR_LO || din == PS2_OVR_HI) begin
          keys      <= '0;
          seq_error <= 1'b1;
          state     <= S_IDLE;
        end else begin
          unique case (state)
            S_IDLE: begin
              if (din == PS2_EXT) begin
                state <= S_EXT;
              end else if (din == PS2_BRK) begin
                state <= S_BRK;
              end else if (!is_discard(din)) begin
                // Pulse only on keys not already held, so typematic repeats stay silent.
                key_make_pulse <= plain_mask & ~keys;
                keys           <= keys | plain_mask;
              end
            end
            S_EXT: begin
              if (din == PS2_BRK) begin
                state <= S_EXT_BRK;
              end else begin
                key_make_pulse <= ext_mask & ~keys;
                keys           <= keys | ext_mask;
                state          <= S_IDLE;
              end
            end
            S_BRK: begin
              keys  <= keys & ~plain_mask;
              state <= S_IDLE;
            end
            S_EXT_BRK: begin
              keys  <= keys & ~ext_mask;
              state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end else if (expired) begin
        state     <= S_IDLE;
        seq_error <= 1'b1;
      end
    end
  end

  assign Key_2_is_pressed     = keys[K2];
  assign Key_4_is_pressed     = keys[K4];
  assign Key_6_is_pressed     = keys[K6];
  assign Key_8_is_pressed     = keys[K8];
  assign Key_ENTER_is_pressed = keys[KENTER];

endmodule

`default_nettype wire

// File: tb/tb_ps2_keypad_decoder.sv
// tb_ps2_keypad_decoder: directed self-checking bench for ps2_keypad_decoder (short timeout for simulation).
`default_nettype none

module tb_ps2_keypad_decoder;

  localparam int T = 16;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_new;
  logic       din_err;
  logic       k2, k4, k6, k8, kent;
  logic [4:0] pulse;
  logic       serr;
  logic [4:0] flags;

  int checks;
  int fails;

  assign flags = {kent, k8, k6, k4, k2};

  ps2_keypad_decoder #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .din                 (din),
    .din_new             (din_new),
    .din_err             (din_err),
    .Key_2_is_pressed    (k2),
    .Key_4_is_pressed    (k4),
    .Key_6_is_pressed    (k6),
    .Key_8_is_pressed    (k8),
    .Key_ENTER_is_pressed(kent),
    .key_make_pulse      (pulse),
    .seq_error           (serr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge, where the byte's result is visible.
  task automatic send_byte(input logic [7:0] b);
    din     = b;
    din_new = 1'b1;
    @(negedge clk);
    din_new = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 8'h00; din_new = 1'b0; din_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({flags, pulse, serr} !== 11'd0) begin
      fails++; $display("FAIL reset_outputs: got flags=%b pulse=%b serr=%b, want all 0", flags, pulse, serr);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_make_break();
    send_byte(8'h72);
    checks++;
    if (flags !== 5'b00001 || pulse !== 5'b00001) begin
      fails++; $display("FAIL make_2: got flags=%b pulse=%b, want 00001/00001", flags, pulse);
    end
    @(negedge clk);
    checks++;
    if (pulse !== 5'b00000) begin
      fails++; $display("FAIL make_2_pulse_width: got pulse=%b, want 00000", pulse);
    end
    send_byte(8'hAA);
    checks++;
    if (flags !== 5'b00001 || pulse !== 5'b00000 || serr !== 1'b0) begin
      fails++; $display("FAIL discard_bat: got flags=%b pulse=%b serr=%b, want 00001/00000/0", flags, pulse, serr);
    end
    send_byte(8'hF0);
    send_byte(8'h72);
    checks++;
    if (flags !== 5'b00000 || pulse !== 5'b00000) begin
      fails++; $display("FAIL break_2: got flags=%b pulse=%b, want 00000/00000", flags, pulse);
    end
  endtask

  task automatic test_typematic();
    int npulse;
    npulse = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h5A);
      if (pulse === 5'b10000) npulse++;
      else if (pulse !== 5'b00000) npulse += 10;
    end
    checks++;
    if (npulse != 1 || flags !== 5'b10000) begin
      fails++; $display("FAIL typematic_enter: got pulses=%0d flags=%b, want 1/10000", npulse, flags);
    end
    send_byte(8'hF0);
    send_byte(8'h5A);
    checks++;
    if (flags !== 5'b00000) begin
      fails++; $display("FAIL break_enter: got flags=%b, want 00000", flags);
    end
  endtask

  task automatic test_extended();
    logic [4:0] exp_f;
    send_byte(8'hE0);
    send_byte(8'h75);
`ifdef PS2_ARROW_ALIAS_EN
    exp_f = 5'b01000;
`else
    exp_f = 5'b00000;
`endif
    checks++;
    if (flags !== exp_f || pulse !== exp_f) begin
      fails++; $display("FAIL ext_arrow_8: got flags=%b pulse=%b, want %b/%b", flags, pulse, exp_f, exp_f);
    end
    // A plain 6B next must decode as a plain make, proving the FSM left EXT.
    send_byte(8'h6B);
    checks++;
    if (flags !== (exp_f | 5'b00010) || pulse !== 5'b00010) begin
      fails++; $display("FAIL ext_back_to_idle: got flags=%b pulse=%b, want %b/00010", flags, pulse, exp_f | 5'b00010);
    end
    send_byte(8'hE0);
    send_byte(8'h5A);
    checks++;
    if (kent !== 1'b1 || pulse !== 5'b10000) begin
      fails++; $display("FAIL ext_enter_make: got enter=%b pulse=%b, want 1/10000", kent, pulse);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    checks++;
    if (kent !== 1'b0 || pulse !== 5'b00000) begin
      fails++; $display("FAIL ext_enter_break: got enter=%b pulse=%b, want 0/00000", kent, pulse);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    send_byte(8'hE0);
    for (int i = 0; i < T - 1; i++) begin
      if (serr !== 1'b0) early++;
      @(negedge clk);
    end
    checks++;
    if (early != 0 || serr !== 1'b0) begin
      fails++; $display("FAIL timeout_early: got %0d early seq_error cycles, serr=%b, want 0/0", early, serr);
    end
    @(negedge clk);
    checks++;
    if (serr !== 1'b1) begin
      fails++; $display("FAIL timeout_pulse: got serr=%b, want 1", serr);
    end
    @(negedge clk);
    checks++;
    if (serr !== 1'b0) begin
      fails++; $display("FAIL timeout_pulse_width: got serr=%b, want 0", serr);
    end
    send_byte(8'h6B);
    checks++;
    if (flags !== 5'b00010 || pulse !== 5'b00010) begin
      fails++; $display("FAIL after_timeout_4: got flags=%b pulse=%b, want 00010/00010", flags, pulse);
    end
    // Byte landing in the expiry cycle is decoded in EXT instead of timing out.
    send_byte(8'hE0);
    for (int i = 0; i < T - 1; i++) @(negedge clk);
    send_byte(8'h5A);
    checks++;
    if (serr !== 1'b0 || kent !== 1'b1 || pulse !== 5'b10000) begin
      fails++; $display("FAIL din_new_beats_timeout: got serr=%b enter=%b pulse=%b, want 0/1/10000", serr, kent, pulse);
    end
    do_reset();
  endtask

  task automatic test_overrun();
    send_byte(8'h6B);
    send_byte(8'h74);
    checks++;
    if (flags !== 5'b00110 || pulse !== 5'b00100) begin
      fails++; $display("FAIL hold_4_6: got flags=%b pulse=%b, want 00110/00100", flags, pulse);
    end
    send_byte(8'hFF);
    checks++;
    if (flags !== 5'b00000 || serr !== 1'b1) begin
      fails++; $display("FAIL overrun_ff: got flags=%b serr=%b, want 00000/1", flags, serr);
    end
    @(negedge clk);
    checks++;
    if (serr !== 1'b0) begin
      fails++; $display("FAIL overrun_pulse_width: got serr=%b, want 0", serr);
    end
    send_byte(8'hF0);
    send_byte(8'h00);
    send_byte(8'h72);
    checks++;
    if (k2 !== 1'b1) begin
      fails++; $display("FAIL overrun_00_from_brk: got key2=%b, want 1", k2);
    end
    do_reset();
  endtask

  task automatic test_din_err();
    send_byte(8'h72);
    send_byte(8'hE0);
    din = 8'h75; din_new = 1'b1; din_err = 1'b1;
    @(negedge clk);
    din_new = 1'b0; din_err = 1'b0;
    checks++;
    if (serr !== 1'b1 || flags !== 5'b00001) begin
      fails++; $display("FAIL din_err: got serr=%b flags=%b, want 1/00001", serr, flags);
    end
    send_byte(8'h74);
    checks++;
    if (flags !== 5'b00101 || pulse !== 5'b00100) begin
      fails++; $display("FAIL after_din_err: got flags=%b pulse=%b, want 00101/00100", flags, pulse);
    end
    do_reset();
  endtask

  task automatic test_reset_midseq();
    send_byte(8'h74);
    send_byte(8'hF0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (flags !== 5'b00000) begin
      fails++; $display("FAIL midseq_reset_flags: got flags=%b, want 00000", flags);
    end
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'h74);
    checks++;
    if (k6 !== 1'b1 || pulse !== 5'b00100) begin
      fails++; $display("FAIL midseq_reset_make6: got key6=%b pulse=%b, want 1/00100", k6, pulse);
    end
  endtask

  task automatic test_back_to_back();
    din = 8'h75; din_new = 1'b1;
    @(negedge clk);
    din = 8'hE0;
    @(negedge clk);
    din = 8'hF0;
    @(negedge clk);
    din = 8'h5A;
    @(negedge clk);
    din = 8'h6B;
    @(negedge clk);
    din_new = 1'b0;
    checks++;
    if (flags !== 5'b01110 || pulse !== 5'b00010) begin
      fails++; $display("FAIL back_to_back: got flags=%b pulse=%b, want 01110/00010", flags, pulse);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_timeout();
    test_overrun();
    test_din_err();
    test_reset_midseq();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
